fifo_arbiter: RTL and testbench

Arbiter and sequencer placed in front of the team's 8-bit, 16-entry (15 usable) FIFO. It shares the FIFO's single command port between two write requesters and one read requester using round-robin arbitration. It generates the FIFO's two-cycle enable protocol and returns read data and completion acknowledges to the requesters.

---
 rtl/fifo_arbiter_if.sv | 33 +++
 rtl/fifo_arbiter.sv | 119 +++++++++++
 tb/tb_fifo_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_arbiter_if.sv
// Requester-side and FIFO-side signals of the FIFO arbiter, bundled for port connection.
// The master modport is the environment (requesters plus FIFO); the slave is the arbiter.
interface fifo_arbiter_if #(
    parameter int DW = 8
);
    logic [1:0]    wr_req;
    logic [DW-1:0] wr_data0;
    logic [DW-1:0] wr_data1;
    logic [1:0]    wr_ack;
    logic          rd_req;
    logic          rd_ack;
    logic [DW-1:0] rd_data;
    logic          fifo_eni;
    logic          fifo_eno;
    logic [DW-1:0] fifo_din;
    logic [DW-1:0] fifo_dout;
    logic [4:0]    fifo_n;
    logic          busy;
    logic [1:0]    last_grant;
    logic [15:0]   op_count;

    modport master (
        output wr_req, wr_data0, wr_data1, rd_req, fifo_dout, fifo_n,
        input  wr_ack, rd_ack, rd_data, fifo_eni, fifo_eno, fifo_din,
               busy, last_grant, op_count
    );

    modport slave (
        input  wr_req, wr_data0, wr_data1, rd_req, fifo_dout, fifo_n,
        output wr_ack, rd_ack, rd_data, fifo_eni, fifo_eno, fifo_din,
               busy, last_grant, op_count
    );
endinterface

// File: rtl/fifo_arbiter.sv
// Round-robin arbiter sharing one FIFO command port between two writers and one reader,
// sequencing the FIFO's two-cycle enable protocol and returning acks and read data.
module fifo_arbiter #(
    parameter int DW  = 8,
    parameter int CAP = 15
) (
    input logic           clk,
    input logic           rst,
    fifo_arbiter_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_OP1,
        S_OP2,
        S_CAP,
        S_DONE
    } state_t;

    localparam logic [4:0] CapN = 5'(CAP);

    state_t        state_q;
    logic [1:0]    grant_q;
    logic          eni_q;
    logic          eno_q;
    logic [DW-1:0] din_q;
    logic [1:0]    wr_ack_q;
    logic          rd_ack_q;
    logic [DW-1:0] rd_data_q;
    logic          busy_q;
    logic [15:0]   op_count_q;

    logic [2:0]    elig_d;
    logic          any_elig_d;
    logic [1:0]    winner_d;

    // Search order begins at the requester after the last grant; 0 = wr0, 1 = wr1, 2 = rd.
    always_comb begin
        elig_d[0]  = bus.wr_req[0] && (bus.fifo_n < CapN);
        elig_d[1]  = bus.wr_req[1] && (bus.fifo_n < CapN);
        elig_d[2]  = bus.rd_req && (bus.fifo_n != 5'd0);
        any_elig_d = |elig_d;
        winner_d   = 2'd0;
        case (grant_q)
            2'd0:    winner_d = elig_d[1] ? 2'd1 : (elig_d[2] ? 2'd2 : 2'd0);
            2'd1:    winner_d = elig_d[2] ? 2'd2 : (elig_d[0] ? 2'd0 : 2'd1);
            default: winner_d = elig_d[0] ? 2'd0 : (elig_d[1] ? 2'd1 : 2'd2);
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            grant_q    <= 2'd2;
            eni_q      <= 1'b0;
            eno_q      <= 1'b0;
            din_q      <= '0;
            wr_ack_q   <= 2'b00;
            rd_ack_q   <= 1'b0;
            rd_data_q  <= '0;
            busy_q     <= 1'b0;
            op_count_q <= 16'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (any_elig_d) begin
                        state_q <= S_OP1;
                        grant_q <= winner_d;
                        busy_q  <= 1'b1;
                        if (winner_d == 2'd0) begin
                            eni_q <= 1'b1;
                            din_q <= bus.wr_data0;
                        end else if (winner_d == 2'd1) begin
                            eni_q <= 1'b1;
                            din_q <= bus.wr_data1;
                        end else begin
                            eno_q <= 1'b1;
                        end
                    end
                end
                S_OP1: state_q <= S_OP2;
                S_OP2: begin
                    state_q <= S_CAP;
                    eni_q   <= 1'b0;
                    eno_q   <= 1'b0;
                end
                // The FIFO's pop data is settled in CAP; acks and the count become visible in DONE.
                S_CAP: begin
                    state_q    <= S_DONE;
                    op_count_q <= op_count_q + 16'd1;
                    if (grant_q == 2'd2) begin
                        rd_ack_q  <= 1'b1;
                        rd_data_q <= bus.fifo_dout;
                    end else begin
                        wr_ack_q <= (grant_q == 2'd0) ? 2'b01 : 2'b10;
                    end
                end
                S_DONE: begin
                    state_q  <= S_IDLE;
                    wr_ack_q <= 2'b00;
                    rd_ack_q <= 1'b0;
                    busy_q   <= 1'b0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.fifo_eni   = eni_q;
    assign bus.fifo_eno   = eno_q;
    assign bus.fifo_din   = din_q;
    assign bus.wr_ack     = wr_ack_q;
    assign bus.rd_ack     = rd_ack_q;
    assign bus.rd_data    = rd_data_q;
    assign bus.busy       = busy_q;
    assign bus.last_grant = grant_q;
    assign bus.op_count   = op_count_q;

endmodule

// File: tb/tb_fifo_arbiter.sv
// Bench for fifo_arbiter: a queue-based FIFO stand-in, a transaction-level reference model,
// directed boundary scenarios and a randomized request phase.
module tb_fifo_arbiter;

    localparam int Cap = 15;

    logic clk = 1'b0;
    logic rst = 1'b0;

    fifo_arbiter_if #(.DW(8)) bus ();

    fifo_arbiter #(.DW(8), .CAP(Cap)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int testsRun    = 0;
    int testsFailed = 0;

    // Reference model: phase counts cycles since the grant (0 = idle, 4 = ack cycle).
    int         phase   = 0;
    int         grantee = 0;
    int         lastG   = 2;
    int         opCnt   = 0;
    logic [7:0] rdD     = 8'h00;
    logic [7:0] dinE    = 8'h00;
    logic [7:0] refQ[$];

    logic [7:0] stubQ[$];
    logic       eniS = 1'b0, enoS = 1'b0, eniPrev = 1'b0, enoPrev = 1'b0;
    logic [7:0] dinS = 8'h00;
    int         ackLog[$];

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        phase = 0;
        grantee = 0;
        lastG = 2;
        opCnt = 0;
        rdD = 8'h00;
        dinE = 8'h00;
        refQ.delete();
    endtask

    task automatic modelStep();
        logic [2:0] elig;
        int n;
        int c;
        bit found;
        n = int'(bus.fifo_n);
        if (phase == 0) begin
            elig[0] = bus.wr_req[0] && (n < Cap);
            elig[1] = bus.wr_req[1] && (n < Cap);
            elig[2] = bus.rd_req && (n != 0);
            found = 1'b0;
            for (int k = 1; k <= 3; k++) begin
                c = (lastG + k) % 3;
                if (!found && elig[c]) begin
                    found = 1'b1;
                    grantee = c;
                end
            end
            if (found) begin
                phase = 1;
                lastG = grantee;
                if (grantee == 0) begin
                    dinE = bus.wr_data0;
                    refQ.push_back(dinE);
                end else if (grantee == 1) begin
                    dinE = bus.wr_data1;
                    refQ.push_back(dinE);
                end
            end
        end else if (phase == 3) begin
            opCnt = (opCnt + 1) % 65536;
            if (grantee == 2 && refQ.size() > 0) rdD = refQ.pop_front();
            phase = 4;
        end else if (phase == 4) begin
            phase = 0;
        end else begin
            phase++;
        end
    endtask

    // FIFO stand-in commits a push or pop once its enable has been seen for two cycles.
    initial begin
        bus.fifo_n = 5'd0;
        bus.fifo_dout = 8'h00;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                modelReset();
                stubQ.delete();
                eniPrev = 1'b0;
                enoPrev = 1'b0;
                bus.fifo_n <= 5'd0;
                bus.fifo_dout <= 8'h00;
            end else begin
                modelStep();
                if (eniS && eniPrev && stubQ.size() < 16) stubQ.push_back(dinS);
                if (enoS && enoPrev && stubQ.size() > 0) bus.fifo_dout <= stubQ.pop_front();
                eniPrev = eniS;
                enoPrev = enoS;
                bus.fifo_n <= 5'(stubQ.size());
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            eniS = bus.fifo_eni;
            enoS = bus.fifo_eno;
            dinS = bus.fifo_din;
            if (!rst) begin
                checkOutput("busy", 32'(bus.busy), 32'(phase != 0));
                checkOutput("fifo_eni", 32'(bus.fifo_eni),
                            32'((phase == 1 || phase == 2) && grantee < 2));
                checkOutput("fifo_eno", 32'(bus.fifo_eno),
                            32'((phase == 1 || phase == 2) && grantee == 2));
                checkOutput("enableExcl", 32'(bus.fifo_eni & bus.fifo_eno), 32'd0);
                checkOutput("wr_ack", 32'(bus.wr_ack),
                            (phase == 4 && grantee < 2) ? (32'd1 << grantee) : 32'd0);
                checkOutput("rd_ack", 32'(bus.rd_ack), 32'(phase == 4 && grantee == 2));
                checkOutput("last_grant", 32'(bus.last_grant), 32'(lastG));
                checkOutput("op_count", 32'(bus.op_count), 32'(opCnt));
                checkOutput("rd_data", 32'(bus.rd_data), 32'(rdD));
                checkOutput("fifo_din", 32'(bus.fifo_din), 32'(dinE));
                if (bus.wr_ack[0]) ackLog.push_back(0);
                if (bus.wr_ack[1]) ackLog.push_back(1);
                if (bus.rd_ack) ackLog.push_back(2);
            end
        end
    end

    // Requesters drop in the ack cycle; with raiseOdds > 0 idle requesters re-raise at random.
    task automatic driveRequesters(input int raiseOdds);
        for (int i = 0; i < 2; i++) begin
            if (bus.wr_req[i] && phase == 4 && grantee == i) begin
                bus.wr_req[i] = 1'b0;
            end else if (!bus.wr_req[i] && raiseOdds > 0 &&
                         $urandom_range(0, raiseOdds - 1) == 0) begin
                bus.wr_req[i] = 1'b1;
                if (i == 0) bus.wr_data0 = 8'($urandom);
                else bus.wr_data1 = 8'($urandom);
            end
        end
        if (bus.rd_req && phase == 4 && grantee == 2) begin
            bus.rd_req = 1'b0;
        end else if (!bus.rd_req && raiseOdds > 0 && $urandom_range(0, raiseOdds - 1) == 0) begin
            bus.rd_req = 1'b1;
        end
    endtask

    task automatic applyStimulus(input int cycles, input int raiseOdds);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            driveRequesters(raiseOdds);
        end
    endtask

    task automatic raiseWrite(input int which, input logic [7:0] data);
        if (which == 0) begin
            bus.wr_data0 = data;
            bus.wr_req[0] = 1'b1;
        end else begin
            bus.wr_data1 = data;
            bus.wr_req[1] = 1'b1;
        end
    endtask

    task automatic runUntilDone(input string tag, input int limit);
        int n;
        n = 0;
        while ((bus.wr_req != 2'b00 || bus.rd_req) && n < limit) begin
            applyStimulus(1, 0);
            n++;
        end
        checkOutput({tag, "_done"}, 32'(n < limit), 32'd1);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_busy"}, 32'(bus.busy), 32'd0);
        checkOutput({tag, "_eni"}, 32'(bus.fifo_eni), 32'd0);
        checkOutput({tag, "_eno"}, 32'(bus.fifo_eno), 32'd0);
        checkOutput({tag, "_din"}, 32'(bus.fifo_din), 32'd0);
        checkOutput({tag, "_acks"}, 32'({bus.wr_ack, bus.rd_ack}), 32'd0);
        checkOutput({tag, "_rd_data"}, 32'(bus.rd_data), 32'd0);
        checkOutput({tag, "_op_count"}, 32'(bus.op_count), 32'd0);
        checkOutput({tag, "_last_grant"}, 32'(bus.last_grant), 32'd2);
    endtask

    initial begin
        int guard;
        bus.wr_req = 2'b00;
        bus.rd_req = 1'b0;
        bus.wr_data0 = 8'h00;
        bus.wr_data1 = 8'h00;

        #2 rst = 1'b1;
        #1 checkResetValues("reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Single write of 0xA5 followed by its read-back.
        raiseWrite(0, 8'hA5);
        runUntilDone("write1", 20);
        bus.rd_req = 1'b1;
        runUntilDone("read1", 20);
        checkOutput("read1_data", 32'(bus.rd_data), 32'hA5);
        checkOutput("read1_count", 32'(bus.op_count), 32'd2);
        applyStimulus(2, 0);

        // Round-robin with all three pending and one byte stored; last grant was wr0.
        raiseWrite(0, 8'h11);
        runUntilDone("rrSeed", 20);
        applyStimulus(2, 0);
        ackLog.delete();
        raiseWrite(0, 8'h21);
        raiseWrite(1, 8'h22);
        bus.rd_req = 1'b1;
        runUntilDone("rr", 40);
        checkOutput("rr_len", 32'(ackLog.size()), 32'd3);
        if (ackLog.size() >= 3) begin
            checkOutput("rr_first", 32'(ackLog[0]), 32'd1);
            checkOutput("rr_second", 32'(ackLog[1]), 32'd2);
            checkOutput("rr_third", 32'(ackLog[2]), 32'd0);
        end

        // Fill to capacity, then a blocked write competes with a read.
        guard = 0;
        while (bus.fifo_n < 5'(Cap) && guard < 20) begin
            applyStimulus(1, 0);
            raiseWrite(0, 8'(8'h40 + guard));
            runUntilDone("fill", 20);
            applyStimulus(2, 0);
            guard++;
        end
        checkOutput("full_level", 32'(bus.fifo_n), 32'(Cap));
        ackLog.delete();
        raiseWrite(1, 8'h99);
        bus.rd_req = 1'b1;
        runUntilDone("full", 40);
        checkOutput("full_len", 32'(ackLog.size()), 32'd2);
        if (ackLog.size() >= 2) begin
            checkOutput("full_first", 32'(ackLog[0]), 32'd2);
            checkOutput("full_second", 32'(ackLog[1]), 32'd1);
        end

        // Reset cut into OP2 of a write: no ack, and wr0 wins the next grant.
        bus.rd_req = 1'b1;
        runUntilDone("drainOne", 20);
        applyStimulus(1, 0);
        ackLog.delete();
        raiseWrite(0, 8'h77);
        guard = 0;
        while (phase != 2 && guard < 10) begin
            applyStimulus(1, 0);
            guard++;
        end
        checkOutput("midop_reached", 32'(phase), 32'd2);
        rst = 1'b1;
        #1 checkResetValues("midop");
        @(negedge clk);
        rst = 1'b0;
        checkOutput("midop_noack", 32'(ackLog.size()), 32'd0);
        raiseWrite(1, 8'h88);
        runUntilDone("postReset", 40);
        checkOutput("postReset_first", (ackLog.size() > 0) ? 32'(ackLog[0]) : 32'd99, 32'd0);

        // Empty FIFO: a held read waits without acks until a write arrives.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        ackLog.delete();
        bus.rd_req = 1'b1;
        applyStimulus(20, 0);
        checkOutput("empty_noack", 32'(ackLog.size()), 32'd0);
        checkOutput("empty_idle", 32'(bus.busy), 32'd0);
        raiseWrite(0, 8'h3C);
        runUntilDone("empty", 40);
        checkOutput("empty_len", 32'(ackLog.size()), 32'd2);
        if (ackLog.size() >= 2) begin
            checkOutput("empty_first", 32'(ackLog[0]), 32'd0);
            checkOutput("empty_second", 32'(ackLog[1]), 32'd2);
        end
        checkOutput("empty_data", 32'(bus.rd_data), 32'h3C);

        // Random traffic; the per-cycle model checks cover pulses, exclusivity and data order.
        applyStimulus(2000, 4);
        applyStimulus(20, 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
